// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// instr_fetch_queue : fetch-PC sequencer and instruction queue toward IF_ID
// Revision 1.0
// ============================================================================
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic                      clk_i_IFQ,
    input  logic                      rst_i_IFQ,
    input  logic                      redirect_i,
    input  logic [31:0]               redirect_pc_i,
    output logic                      imem_req_o,
    output logic [31:0]               imem_addr_o,
    input  logic [31:0]               imem_rdata_i,
    output logic                      instr_valid_o,
    output logic [31:0]               instr_o,
    output logic [31:0]               pc_addr_o,
    input  logic                      instr_ready_i,
    output logic [$clog2(QDEPTH):0]   q_count_o
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     req_addr_q, req_addr_d;
    logic            inflight_q, inflight_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [31:0]     instr_mem_q [QDEPTH];
    logic [31:0]     addr_mem_q  [QDEPTH];

    logic            w_discard;
    logic            w_inflight;
    logic [OW-1:0]   w_occ;
    logic            w_req;
    logic            w_push;
    logic            w_pop;
    logic            w_unused;

    // The two low target bits are dropped: fetch is always word aligned.
    assign w_unused = ^redirect_pc_i[1:0];

    always_comb begin
        w_discard  = (state_q == ST_FLUSH) || redirect_i;
        w_inflight = inflight_q && !w_discard;
        w_occ      = {1'b0, count_q} + OW'(w_inflight);
        w_req      = (state_q != ST_BOOT) && !redirect_i && (w_occ < OW'(QDEPTH));
        w_push     = w_inflight;
        w_pop      = (count_q != '0) && instr_ready_i;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        inflight_d = w_req;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN:   state_d = redirect_i ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_d = redirect_i ? ST_FLUSH : ST_RUN;
            default:  state_d = ST_BOOT;
        endcase

        if (w_req) begin
            req_addr_d = pc_q;
        end

        // A redirect wins over any same-cycle push, pop or PC advance.
        if (redirect_i) begin
            pc_d     = {redirect_pc_i[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_req) begin
                pc_d = pc_q + 32'd4;
            end
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk_i_IFQ or posedge rst_i_IFQ) begin
        if (rst_i_IFQ) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk_i_IFQ) begin
        if (w_push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata_i;
            addr_mem_q[wr_ptr_q]  <= req_addr_q;
        end
    end

    // Head data is masked while empty so reset and flush show zeros.
    assign imem_req_o    = w_req;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = (count_q != '0);
    assign instr_o       = instr_valid_o ? instr_mem_q[rd_ptr_q] : 32'h0;
    assign pc_addr_o     = instr_valid_o ? addr_mem_q[rd_ptr_q]  : 32'h0;
    assign q_count_o     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch_queue : directed self-checking bench for instr_fetch_queue
// Revision 1.0
// ============================================================================
module tb_instr_fetch_queue;

    localparam int QDEPTH = 4;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_addr;
    logic        ready;
    logic [2:0]  q_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem_addr_q;

    instr_fetch_queue #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk_i_IFQ     (clk),
        .rst_i_IFQ     (rst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .pc_addr_o     (pc_addr),
        .instr_ready_i (ready),
        .q_count_o     (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns address + 0x100, one cycle after the request.
    always @(posedge clk) begin
        if (imem_req) mem_addr_q <= imem_addr;
    end
    assign imem_rdata = mem_addr_q + 32'h100;

    always @(negedge clk) begin
        if (!rst) begin
            n_assert++;
            assert (q_count <= 3'(QDEPTH)) else begin
                n_fail++;
                $error("FAIL overflow observed=%0d expected<=%0d", q_count, QDEPTH);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        ready       = 1'b1;

        // Reset values and streaming with ready held high
        #12;
        chk("rst_req",   {31'h0, imem_req},    32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr,                32'h0);
        chk("rst_pc",    pc_addr,              32'h0);
        chk("rst_count", {29'h0, q_count},     32'h0);
        do_reset();
        chk("boot_req",  {31'h0, imem_req},    32'h0);
        tick();
        chk("c1_req",    {31'h0, imem_req},    32'h1);
        chk("c1_addr",   imem_addr,            32'h0);
        chk("c1_valid",  {31'h0, instr_valid}, 32'h0);
        tick();
        chk("c2_req",    {31'h0, imem_req},    32'h1);
        chk("c2_addr",   imem_addr,            32'h4);
        chk("c2_valid",  {31'h0, instr_valid}, 32'h0);
        for (int k = 3; k <= 8; k++) begin
            tick();
            chk("str_valid", {31'h0, instr_valid}, 32'h1);
            chk("str_pc",    pc_addr,   32'((k - 3) * 4));
            chk("str_instr", instr,     32'((k - 3) * 4) + 32'h100);
            chk("str_addr",  imem_addr, 32'((k - 1) * 4));
            chk("str_count", {29'h0, q_count}, 32'h1);
        end

        // Backpressure: queue fills, fetch stops, then drains in order
        ready = 1'b0;
        do_reset();
        repeat (10) tick();
        chk("bp_count", {29'h0, q_count},     32'h4);
        chk("bp_req",   {31'h0, imem_req},    32'h0);
        chk("bp_valid", {31'h0, instr_valid}, 32'h1);
        chk("bp_pc",    pc_addr,              32'h0);
        chk("bp_instr", instr,                32'h100);
        ready = 1'b1;
        #1;
        chk("dr_pc0", pc_addr, 32'h0);
        tick();
        chk("dr_pc4",   pc_addr,           32'h4);
        chk("dr_req",   {31'h0, imem_req}, 32'h1);
        chk("dr_addr",  imem_addr,         32'h10);
        tick();
        chk("dr_pc8",   pc_addr, 32'h8);
        tick();
        chk("dr_pc12",  pc_addr, 32'hC);
        tick();
        chk("dr_pc16",  pc_addr, 32'h10);
        chk("dr_valid", {31'h0, instr_valid}, 32'h1);

        // Redirect with three entries queued
        ready = 1'b0;
        do_reset();
        repeat (5) tick();
        chk("rd_pre_count", {29'h0, q_count}, 32'h3);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        #1;
        chk("rd_T_req", {31'h0, imem_req}, 32'h0);
        tick();
        redirect = 1'b0;
        #1;
        chk("rd_T1_count", {29'h0, q_count},     32'h0);
        chk("rd_T1_valid", {31'h0, instr_valid}, 32'h0);
        chk("rd_T1_req",   {31'h0, imem_req},    32'h1);
        chk("rd_T1_addr",  imem_addr,            32'h200);
        tick();
        chk("rd_T2_count", {29'h0, q_count},     32'h0);
        chk("rd_T2_addr",  imem_addr,            32'h204);
        tick();
        chk("rd_T3_valid", {31'h0, instr_valid}, 32'h1);
        chk("rd_T3_pc",    pc_addr,              32'h200);
        chk("rd_T3_instr", instr,                32'h300);

        // Back-to-back redirects: only the newest target is delivered
        tick();
        ready       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        #1;
        chk("rr_T_req", {31'h0, imem_req}, 32'h0);
        tick();
        redirect_pc = 32'h800;
        #1;
        chk("rr_T1_req",   {31'h0, imem_req},    32'h0);
        chk("rr_T1_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        redirect = 1'b0;
        #1;
        chk("rr_T2_req",   {31'h0, imem_req},    32'h1);
        chk("rr_T2_addr",  imem_addr,            32'h800);
        chk("rr_T2_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        chk("rr_T3_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        chk("rr_T4_valid", {31'h0, instr_valid}, 32'h1);
        chk("rr_T4_pc",    pc_addr,              32'h800);
        chk("rr_T4_instr", instr,                32'h900);
        tick();
        chk("rr_T5_pc",    pc_addr,              32'h804);

        // Fetch PC wraps past the top of the address space
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        #1;
        chk("wr_addr_top", imem_addr, 32'hFFFF_FFFC);
        chk("wr_req_top",  {31'h0, imem_req}, 32'h1);
        tick();
        chk("wr_addr_zero", imem_addr, 32'h0);
        chk("wr_req_zero",  {31'h0, imem_req}, 32'h1);
        tick();
        chk("wr_pc_top",    pc_addr, 32'hFFFF_FFFC);
        chk("wr_instr_top", instr,   32'h0000_00FC);
        tick();
        chk("wr_pc_zero",    pc_addr, 32'h0);
        chk("wr_instr_zero", instr,   32'h100);

        // Asynchronous reset pulse between edges with two entries queued
        ready = 1'b0;
        do_reset();
        repeat (4) tick();
        chk("ar_pre_count", {29'h0, q_count}, 32'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", {31'h0, instr_valid}, 32'h0);
        chk("ar_count", {29'h0, q_count},     32'h0);
        chk("ar_pc",    pc_addr,              32'h0);
        chk("ar_instr", instr,                32'h0);
        chk("ar_req",   {31'h0, imem_req},    32'h0);
        #2;
        rst = 1'b0;
        tick();
        chk("ar_c1_count", {29'h0, q_count},     32'h0);
        chk("ar_c1_valid", {31'h0, instr_valid}, 32'h0);
        chk("ar_c1_req",   {31'h0, imem_req},    32'h1);
        chk("ar_c1_addr",  imem_addr,            32'h0);
        tick();
        chk("ar_c2_count", {29'h0, q_count},     32'h0);
        chk("ar_c2_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        chk("ar_c3_valid", {31'h0, instr_valid}, 32'h1);
        chk("ar_c3_pc",    pc_addr,              32'h0);
        chk("ar_c3_instr", instr,                32'h100);
        chk("ar_c3_count", {29'h0, q_count},     32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
